// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: datapath width,
// the canonical NOP encoding and the fetch FSM state type.
package pc_fetch_unit_pkg;

   localparam int unsigned XLEN = 32;

   // addi x0, x0, 0
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_pc_incrementer.sv
// Sequential next-PC adder: pc + 4, wrapping modulo 2^XLEN.
module pc_incrementer
   import pc_fetch_unit_pkg::*;
(
   input  logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4
);

   assign pc_plus4 = pc + XLEN'(4);

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: holds the PC, issues single-outstanding requests
// to instruction memory and presents each fetched word to decode.
// Optional build macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect targets
// are reported on if_fetch_misalign_o instead of being fetched).
module pc_fetch_unit
   import pc_fetch_unit_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_rvalid_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   output logic            if_valid_o,
   input  logic            if_ready_i,
   output logic [XLEN-1:0] if_instr_o,
   output logic [XLEN-1:0] if_pc_o,
   output logic [XLEN-1:0] if_pc_plus4_o
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   output logic            if_fetch_misalign_o
`endif
);

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic            kill_q, kill_d;
   logic [XLEN-1:0] instr_q, instr_d;
   logic [XLEN-1:0] ipc_q, ipc_d;
   logic [XLEN-1:0] ipc4_q, ipc4_d;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] inc_in, inc_out;
   logic            misaligned;
   logic            locked;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic misalign_q, misalign_d;

   assign target     = redirect_pc_i;
   assign misaligned = redirect_i && (redirect_pc_i[1:0] != 2'b00);
   assign locked     = misalign_q;
   assign if_fetch_misalign_o = misalign_q;
`else
   // Low target bits are forced to zero; no misalignment can be observed.
   assign target     = {redirect_pc_i[XLEN-1:2], redirect_pc_i[1:0] & 2'b00};
   assign misaligned = 1'b0;
   assign locked     = 1'b0;
`endif

   // The single incrementer also produces the link value of a trapped target.
   assign inc_in = misaligned ? target : pc_q;

   pc_incrementer u_inc (
      .pc       (inc_in),
      .pc_plus4 (inc_out)
   );

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         addr_q     <= RESET_PC;
         kill_q     <= 1'b0;
         instr_q    <= NOP_INSTR;
         ipc_q      <= RESET_PC;
         ipc4_q     <= RESET_PC + XLEN'(4);
`ifdef FETCH_MISALIGN_TRAP_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         addr_q     <= addr_d;
         kill_q     <= kill_d;
         instr_q    <= instr_d;
         ipc_q      <= ipc_d;
         ipc4_q     <= ipc4_d;
`ifdef FETCH_MISALIGN_TRAP_EN
         misalign_q <= misalign_d;
`endif
      end
   end

   // Next-state, next-PC, kill and capture logic; redirect overrides last
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      kill_d  = kill_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      ipc4_d  = ipc4_q;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_d = misalign_q;
`endif

      case (state_q)
         IDLE: state_d = FETCH;
         FETCH: begin
            if (imem_rvalid_i) begin
               kill_d = 1'b0;
               if (!redirect_i && !kill_q) begin
                  instr_d = imem_rdata_i;
                  ipc_d   = pc_q;
                  ipc4_d  = inc_out;
                  state_d = HOLD;
               end
            end else if (redirect_i) begin
               kill_d = 1'b1;
            end
         end
         HOLD: begin
            if (if_ready_i && !locked) begin
               pc_d    = inc_out;
               state_d = FETCH;
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            // An orphaned response can still land while a trap is held.
            if (imem_rvalid_i) kill_d = 1'b0;
`endif
         end
         default: state_d = IDLE;
      endcase

      if (redirect_i) begin
         pc_d = target;
         if (state_q == HOLD) state_d = FETCH;
`ifdef FETCH_MISALIGN_TRAP_EN
         misalign_d = 1'b0;
         if (misaligned) begin
            state_d    = HOLD;
            misalign_d = 1'b1;
            instr_d    = NOP_INSTR;
            ipc_d      = target;
            ipc4_d     = inc_out;
         end
`endif
      end

      // The request address only moves when no request is left outstanding.
      if (state_q == FETCH && state_d == FETCH && !imem_rvalid_i)
         addr_d = addr_q;
      else
         addr_d = pc_d;
   end

   assign imem_req_o    = (state_q == FETCH);
   assign imem_addr_o   = addr_q;
   assign if_valid_o    = (state_q == HOLD);
   assign if_instr_o    = instr_q;
   assign if_pc_o       = ipc_q;
   assign if_pc_plus4_o = ipc4_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with an inline instruction-memory model
// whose response word is the address XOR 32'hDEAD_0000.
module tb_pc_fetch_unit;

   logic        clk;
   logic        rst;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        if_valid_o;
   logic        if_ready_i;
   logic [31:0] if_instr_o;
   logic [31:0] if_pc_o;
   logic [31:0] if_pc_plus4_o;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        if_fetch_misalign_o;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   logic        mem_pending;
   int          mem_cnt;
   logic [31:0] mem_addr;
   int          lat;

   pc_fetch_unit #(.RESET_PC(32'h0000_1000)) dut (
      .clk           (clk),
      .rst           (rst),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .if_valid_o    (if_valid_o),
      .if_ready_i    (if_ready_i),
      .if_instr_o    (if_instr_o),
      .if_pc_o       (if_pc_o),
      .if_pc_plus4_o (if_pc_plus4_o)
`ifdef FETCH_MISALIGN_TRAP_EN
      ,
      .if_fetch_misalign_o (if_fetch_misalign_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // One clock, then the memory model reacts to the new cycle's outputs.
   task automatic tick();
      @(posedge clk);
      #1;
      imem_rvalid_i = 1'b0;
      if (mem_pending) begin
         mem_cnt--;
         if (mem_cnt == 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_addr ^ 32'hDEAD_0000;
            mem_pending   = 1'b0;
         end
      end else if (imem_req_o) begin
         mem_pending = 1'b1;
         mem_cnt     = lat;
         mem_addr    = imem_addr_o;
      end
   endtask

   task automatic wait_valid(input string tag);
      for (int n = 0; n < 20 && !if_valid_o; n++) tick();
      check(tag, {31'b0, if_valid_o}, 32'd1);
   endtask

   initial begin
      rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; if_ready_i = 1'b0;
      imem_rvalid_i = 1'b0; imem_rdata_i = '0;
      mem_pending = 1'b0; mem_cnt = 0; mem_addr = '0; lat = 1;
      tick(); tick();

      check("rst_req",   {31'b0, imem_req_o}, 32'd0);
      check("rst_addr",  imem_addr_o,   32'h0000_1000);
      check("rst_valid", {31'b0, if_valid_o}, 32'd0);
      check("rst_instr", if_instr_o,    32'h0000_0013);
      check("rst_pc",    if_pc_o,       32'h0000_1000);
      check("rst_pc4",   if_pc_plus4_o, 32'h0000_1004);

      rst = 1'b0;
      #1;
      check("idle_req", {31'b0, imem_req_o}, 32'd0);
      tick();
      check("first_req",  {31'b0, imem_req_o}, 32'd1);
      check("first_addr", imem_addr_o, 32'h0000_1000);
      tick();
      tick();
      check("hold_valid", {31'b0, if_valid_o}, 32'd1);
      check("hold_instr", if_instr_o,    32'hDEAD_1000);
      check("hold_pc",    if_pc_o,       32'h0000_1000);
      check("hold_pc4",   if_pc_plus4_o, 32'h0000_1004);

      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_valid", {31'b0, if_valid_o}, 32'd1);
         check("stall_req",   {31'b0, imem_req_o}, 32'd0);
         check("stall_instr", if_instr_o, 32'hDEAD_1000);
         check("stall_pc",    if_pc_o,    32'h0000_1000);
      end

      if_ready_i = 1'b1;
      tick();
      if_ready_i = 1'b0;
      check("acc_req",  {31'b0, imem_req_o}, 32'd1);
      check("acc_addr", imem_addr_o, 32'h0000_1004);
      wait_valid("v1004");
      check("pc_1004",    if_pc_o,       32'h0000_1004);
      check("instr_1004", if_instr_o,    32'hDEAD_1004);
      check("pc4_1004",   if_pc_plus4_o, 32'h0000_1008);

      // Redirect while the 1008 fetch is outstanding (latency 3)
      lat = 3;
      if_ready_i = 1'b1;
      tick();
      if_ready_i = 1'b0;
      check("req_1008", imem_addr_o, 32'h0000_1008);
      redirect_i = 1'b1; redirect_pc_i = 32'h0000_2000;
      tick();
      redirect_i = 1'b0;
      check("kill_req_held",  {31'b0, imem_req_o}, 32'd1);
      check("kill_addr_held", imem_addr_o, 32'h0000_1008);
      wait_valid("v2000");
      check("kill_pc",    if_pc_o,    32'h0000_2000);
      check("kill_instr", if_instr_o, 32'hDEAD_2000);

      // Redirect and accept in the same cycle
      lat = 1;
      if_ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h0000_3000;
      tick();
      if_ready_i = 1'b0; redirect_i = 1'b0;
      check("racc_addr", imem_addr_o, 32'h0000_3000);
      wait_valid("v3000");
      check("racc_pc",  if_pc_o,       32'h0000_3000);
      check("racc_pc4", if_pc_plus4_o, 32'h0000_3004);

      // PC wrap at the top of the address space
      redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
      tick();
      redirect_i = 1'b0;
      check("top_addr", imem_addr_o, 32'hFFFF_FFFC);
      wait_valid("vtop");
      check("top_pc",  if_pc_o,       32'hFFFF_FFFC);
      check("top_pc4", if_pc_plus4_o, 32'h0000_0000);
      if_ready_i = 1'b1;
      tick();
      if_ready_i = 1'b0;
      check("wrap_addr", imem_addr_o, 32'h0000_0000);
      wait_valid("vwrap");
      check("wrap_pc", if_pc_o, 32'h0000_0000);

      // Redirect coinciding with the response
      if_ready_i = 1'b1;
      tick();
      if_ready_i = 1'b0;
      tick();
      redirect_i = 1'b1; redirect_pc_i = 32'h0000_4000;
      tick();
      redirect_i = 1'b0;
      check("rrv_valid", {31'b0, if_valid_o}, 32'd0);
      check("rrv_addr",  imem_addr_o, 32'h0000_4000);
      wait_valid("v4000");
      check("rrv_pc",    if_pc_o,    32'h0000_4000);
      check("rrv_instr", if_instr_o, 32'hDEAD_4000);

      // Misaligned redirect target
      redirect_i = 1'b1; redirect_pc_i = 32'h0000_2002;
      tick();
      redirect_i = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      tick();
      check("mis_flag",  {31'b0, if_fetch_misalign_o}, 32'd1);
      check("mis_valid", {31'b0, if_valid_o}, 32'd1);
      check("mis_req",   {31'b0, imem_req_o}, 32'd0);
      check("mis_pc",    if_pc_o,    32'h0000_2002);
      check("mis_instr", if_instr_o, 32'h0000_0013);
`else
      check("mis_req",  {31'b0, imem_req_o}, 32'd1);
      check("mis_addr", imem_addr_o, 32'h0000_2000);
`endif

      // Reset asserted mid-operation takes effect without a clock edge
      rst = 1'b1;
      #1;
      check("mrst_req",   {31'b0, imem_req_o}, 32'd0);
      check("mrst_addr",  imem_addr_o,   32'h0000_1000);
      check("mrst_valid", {31'b0, if_valid_o}, 32'd0);
      check("mrst_instr", if_instr_o,    32'h0000_0013);
      check("mrst_pc",    if_pc_o,       32'h0000_1000);
      check("mrst_pc4",   if_pc_plus4_o, 32'h0000_1004);

      // Stale response arriving in IDLE is ignored
      mem_pending = 1'b0;
      tick();
      rst = 1'b0;
      imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD0_0BAD;
      tick();
      check("stale_valid", {31'b0, if_valid_o}, 32'd0);
      check("stale_addr",  imem_addr_o, 32'h0000_1000);
      tick();
      tick();
      check("stale_pc",    if_pc_o,    32'h0000_1000);
      check("stale_instr", if_instr_o, 32'hDEAD_1000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
